ula_arbiter: RTL
================

ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32 each, signed  operands.
REQ-007 req0_func / req1_func  input  3 each  ULA function code.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result available for requester N.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester N consumes the result.
REQ-010 rsp_r  output  32, signed  registered ULA result, shared by both response ports.
REQ-011 rsp_v  output  1  registered ULA pinV flag, shared.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block shall own exactly one ULA instance and serialise both requesters onto it.
REQ-014 FSM states: IDLE, EXEC, RESP.
REQ-015 IDLE: grant is a combinational function of req valids and last_grant; reqN_ready = (state==IDLE) && grant==N; at most one ready high per cycle.
REQ-016 Round-robin (FAIR=1): if both valid, grant the requester not equal to last_grant; if one valid, grant it.
REQ-017 Fixed priority (FAIR=0): requester 0 wins whenever req0_valid is high.
REQ-018 Accept = reqN_valid && reqN_ready; on the accept edge, latch a, b, func into operand registers, latch owner id, go to EXEC.
REQ-019 EXEC (exactly one cycle): ULA driven from operand registers only; on the next edge capture R into rsp_r and pinV into rsp_v, go to RESP.
REQ-020 RESP: rspN_valid high only for N = owner; rsp_r and rsp_v stable while in RESP.
REQ-021 On rspN_valid && rspN_ready: set last_grant = owner, go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-022 Latency: rspN_valid rises in the second cycle after the accept edge; peak throughput is one operation per 3 cycles.
REQ-023 No request is accepted in EXEC or RESP; both readys are low there.
REQ-024 Requesters shall hold a, b, func stable while valid && !ready; the arbiter samples them only on the accept edge.
REQ-025 A requester dropping valid before acceptance forfeits its slot without error.
REQ-026 rspN_ready asserted while rspN_valid is low shall be ignored.
REQ-027 Arithmetic: width, signedness and overflow semantics are those of ULA; no additional saturation or extension.

Reset
REQ-028 In any cycle with rst high: state = IDLE, rsp0_valid = rsp1_valid = 0, rsp_r = 0, rsp_v = 0, busy = 0, last_grant = 1 (requester 0 wins the first tie), operand registers = 0.
REQ-029 rst high during EXEC or RESP shall abort the in-flight operation; no response is ever issued for it.
REQ-030 Readys shall be low while rst is high.

Structure
REQ-031 Package ula_pkg shall hold: FSM state encoding, ULA function-code constants (including ULA_ADD, ULA_SUB), requester id type.
REQ-032 Sub-module: the existing ULA instantiated once, unmodified; arbitration logic stays inline.

Verification
REQ-033 Single op: req0 ADD a=5, b=7 -> req0_ready in the same cycle; rsp0_valid two cycles later with rsp_r=12, rsp_v=0; rsp1_valid stays 0.
REQ-034 Tie, FAIR=1: both valid every cycle from reset, rsp always ready -> grants alternate 0,1,0,1; each response goes only to the owner's port.
REQ-035 Tie, FAIR=0: both valid continuously -> requester 0 granted every time; req1 starved while req0_valid is high.
REQ-036 Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid, rsp_r, rsp_v stable; both readys low; busy=1 throughout.
REQ-037 Overflow: ADD a=32'h7FFFFFFF, b=1 -> rsp_r=32'h80000000 and rsp_v equal to the ULA pinV for the same operands.
REQ-038 Reset mid-op: rst pulsed in the EXEC cycle -> no rsp valid, state IDLE, next req0 accepted with a fresh result.

Source files
------------

// File: rtl/ula_pkg.sv
// ============================================================================
// ula_pkg : shared types and constants for the ULA and its arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] ULA_ADD = 3'd0;
    localparam logic [2:0] ULA_SUB = 3'd1;
    localparam logic [2:0] ULA_AND = 3'd2;
    localparam logic [2:0] ULA_OR  = 3'd3;
    localparam logic [2:0] ULA_XOR = 3'd4;
    localparam logic [2:0] ULA_SLT = 3'd5;
    localparam logic [2:0] ULA_SLL = 3'd6;
    localparam logic [2:0] ULA_SRL = 3'd7;

    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/ula.sv
// ============================================================================
// ula : 32-bit signed combinational ALU; pinv flags signed overflow on ADD/SUB
// Rev 1.0
// ============================================================================
`default_nettype none

module ula
    import ula_pkg::*;
(
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    input  logic        [2:0]  i_func,
    output logic signed [31:0] o_r,
    output logic               o_pinv
);

    logic signed [31:0] w_sum;
    logic signed [31:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_r    = '0;
        o_pinv = 1'b0;
        case (i_func)
            ULA_ADD: begin
                o_r    = w_sum;
                o_pinv = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            ULA_SUB: begin
                o_r    = w_diff;
                o_pinv = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            ULA_AND: o_r = i_a & i_b;
            ULA_OR:  o_r = i_a | i_b;
            ULA_XOR: o_r = i_a ^ i_b;
            ULA_SLT: o_r = {31'd0, (i_a < i_b)};
            ULA_SLL: o_r = i_a << i_b[4:0];
            ULA_SRL: o_r = $signed($unsigned(i_a) >> i_b[4:0]);
            default: o_r = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ula_arbiter.sv
// ============================================================================
// ula_arbiter : serialises two requesters onto one ULA (IDLE -> EXEC -> RESP)
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_arbiter
    import ula_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic signed [31:0] req0_a,
    input  logic signed [31:0] req0_b,
    input  logic signed [31:0] req1_a,
    input  logic signed [31:0] req1_b,
    input  logic        [2:0]  req0_func,
    input  logic        [2:0]  req1_func,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    input  logic               rsp0_ready,
    input  logic               rsp1_ready,
    output logic signed [31:0] rsp_r,
    output logic               rsp_v,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    req_id_t            r_owner;
    req_id_t            r_last_grant;
    req_id_t            w_grant;
    logic signed [31:0] r_a;
    logic signed [31:0] r_b;
    logic        [2:0]  r_func;
    logic signed [31:0] r_rsp_r;
    logic               r_rsp_v;
    logic signed [31:0] w_ula_r;
    logic               w_ula_v;
    logic               w_idle;
    logic               w_accept;
    logic               w_rsp_fire;

    always_comb begin
        w_grant = r_last_grant;
        if (FAIR != 0) begin
            if (req0_valid && req1_valid) w_grant = ~r_last_grant;
            else if (req0_valid)          w_grant = 1'b0;
            else if (req1_valid)          w_grant = 1'b1;
        end else begin
            if (req0_valid)               w_grant = 1'b0;
            else if (req1_valid)          w_grant = 1'b1;
        end
    end

    // Outputs are gated by rst so nothing is offered or flagged during reset cycles.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign req0_ready = w_idle && req0_valid && (w_grant == 1'b0);
    assign req1_ready = w_idle && req1_valid && (w_grant == 1'b1);
    assign w_accept   = req0_ready || req1_ready;

    assign rsp0_valid = (r_state == ST_RESP) && (r_owner == 1'b0) && !rst;
    assign rsp1_valid = (r_state == ST_RESP) && (r_owner == 1'b1) && !rst;
    assign w_rsp_fire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign busy       = (r_state != ST_IDLE) && !rst;
    assign rsp_r      = r_rsp_r;
    assign rsp_v      = r_rsp_v;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_fire) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_func       <= '0;
            r_rsp_r      <= '0;
            r_rsp_v      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_grant;
                r_a     <= (w_grant == 1'b1) ? req1_a    : req0_a;
                r_b     <= (w_grant == 1'b1) ? req1_b    : req0_b;
                r_func  <= (w_grant == 1'b1) ? req1_func : req0_func;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_r <= w_ula_r;
                r_rsp_v <= w_ula_v;
            end
            if (w_rsp_fire) begin
                r_last_grant <= r_owner;
            end
        end
    end

    ula u_ula (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_func (r_func),
        .o_r    (w_ula_r),
        .o_pinv (w_ula_v)
    );

endmodule

`default_nettype wire
